seq_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 26 ++
 rtl/fulladder.sv | 19 +
 rtl/seq_multiplier_ripple_adder_n.sv | 35 +++
 rtl/seq_multiplier.sv | 143 ++++++++++++++
 tb/tb_seq_multiplier.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and helpers for the sequential shift-add
//               multiplier: FSM state encoding, default width, and counter
//               width calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // FSM state encoding; 2'd3 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

  localparam int MULT_WIDTH_DEFAULT = 8;

  // Iteration counter width; never narrower than one bit
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fulladder.sv
`default_nettype none
// ============================================================================
// Module      : fulladder
// Description : Single-bit full adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/seq_multiplier_ripple_adder_n.sv
`default_nettype none
// ============================================================================
// Module      : ripple_adder_n
// Description : N-bit ripple-carry adder chained from fulladder cells.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_adder_n #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] w_carry;

  assign w_carry[0] = ci;

  // One full adder per bit, carry rippling from LSB to MSB
  for (genvar i = 0; i < N; i++) begin : g_bit
    fulladder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_carry[i]),
      .s  (s[i]),
      .co (w_carry[i+1])
    );
  end

  assign co = w_carry[N];

endmodule
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
//               signed or unsigned, with start/done handshake. Signed
//               operands are multiplied as magnitudes and the sign is
//               applied once at the end.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 Signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int c_PW = 2 * WIDTH;
  localparam int c_CW = cnt_width(WIDTH);

  localparam logic [c_CW-1:0]  c_LAST    = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0]  c_CNT_ONE = c_CW'(1);
  localparam logic [c_PW-1:0]  c_ONE_PW  = c_PW'(1);
  localparam logic [WIDTH-1:0] c_ONE_W   = WIDTH'(1);

  mult_state_t      r_state;
  mult_state_t      w_next_state;

  logic [c_PW-1:0]  r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [c_PW-1:0]  r_acc;
  logic [c_CW-1:0]  r_cnt;
  logic             r_neg;
  logic [c_PW-1:0]  r_p;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_neg;
  logic [c_PW-1:0]  w_addend;
  logic [c_PW-1:0]  w_sum;
  logic             w_unused_co;
  logic [c_PW-1:0]  w_result;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which
  // still fits unsigned
  assign w_mag_a  = (Signed_mode && A[WIDTH-1]) ? (~A + c_ONE_W) : A;
  assign w_mag_b  = (Signed_mode && B[WIDTH-1]) ? (~B + c_ONE_W) : B;
  assign w_neg    = Signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);

  // Partial product selected by the current multiplier LSB
  assign w_addend = r_mplier[0] ? r_mcand : '0;

  ripple_adder_n #(
    .N (c_PW)
  ) u_acc_adder (
    .a  (r_acc),
    .b  (w_addend),
    .ci (1'b0),
    .s  (w_sum),
    .co (w_unused_co)
  );

  // Sign correction on the final accumulated magnitude
  assign w_result = r_neg ? (~w_sum + c_ONE_PW) : w_sum;

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    Busy         = 1'b0;
    Done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        Busy = 1'b1;
        if (r_cnt == c_LAST) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        Done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture in IDLE, shift-add in RUN, product written on the
  // edge that enters DONE so P is valid while Done is high
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_p      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= w_neg;
          end
        end
        ST_RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_LAST) r_p <= w_result;
        end
        default: begin
        end
      endcase
    end
  end

  assign P = r_p;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier at WIDTH=8 and
//               WIDTH=4 against an integer-arithmetic product model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;

  logic        st8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;

  logic        st4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  p4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .Clk (Clk), .Rst (Rst), .Start (st8), .Signed_mode (sm8),
    .A (a8), .B (b8), .Busy (busy8), .Done (done8), .P (p8)
  );

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .Clk (Clk), .Rst (Rst), .Start (st4), .Signed_mode (sm4),
    .A (a4), .B (b4), .Busy (busy4), .Done (done4), .P (p4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product: operands as integers, plain multiply, keep 2*w bits
  function automatic logic [31:0] ref_prod(input int w, input int unsigned a,
                                           input int unsigned b, input bit s);
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (s && ((a >> (w - 1)) & 1) == 1) x = x - (longint'(1) << w);
    if (s && ((b >> (w - 1)) & 1) == 1) y = y - (longint'(1) << w);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic set_in(input int w, input bit st, input int unsigned a,
                        input int unsigned b, input bit s);
    if (w == 8) begin
      st8 = st; a8 = 8'(a); b8 = 8'(b); sm8 = s;
    end else begin
      st4 = st; a4 = 4'(a); b4 = 4'(b); sm4 = s;
    end
  endtask

  function automatic logic [31:0] rd_p(input int w);
    return (w == 8) ? 32'(p8) : 32'(p4);
  endfunction

  function automatic logic rd_busy(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction

  function automatic logic rd_done(input int w);
    return (w == 8) ? done8 : done4;
  endfunction

  // One multiply with latency, busy-count, hold and result checks
  task automatic run_op(input int w, input int unsigned a, input int unsigned b,
                        input bit s, input string tag);
    int          cyc;
    int          nbusy;
    bit          pchg;
    logic [31:0] p_before;
    logic [31:0] exp;
    logic [31:0] got;
    exp = ref_prod(w, a, b, s);
    @(negedge Clk);
    p_before = rd_p(w);
    set_in(w, 1'b1, a, b, s);
    @(negedge Clk);
    set_in(w, 1'b0, $urandom, $urandom, 1'($urandom));
    cyc   = 1;
    nbusy = 0;
    pchg  = 1'b0;
    while (!rd_done(w) && cyc <= 3 * w) begin
      if (rd_busy(w)) nbusy++;
      if (rd_p(w) !== p_before) pchg = 1'b1;
      @(negedge Clk);
      cyc++;
    end
    got = rd_p(w);
    check({tag, "_latency"}, 32'(cyc), 32'(w + 1));
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(w));
    check({tag, "_p_stable_in_run"}, 32'(pchg), 32'd0);
    check({tag, "_busy_with_done"}, 32'(rd_busy(w)), 32'd0);
    check({tag, "_product"}, got, exp);
    @(negedge Clk);
    check({tag, "_done_pulse_len"}, 32'(rd_done(w)), 32'd0);
    check({tag, "_p_hold"}, rd_p(w), got);
  endtask

  initial begin
    int          ndone;
    int          dcyc [4];
    logic [31:0] dp   [4];
    int unsigned cap_a0, cap_b0, cap_a10, cap_b10;

    // Reset state
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_p8", 32'(p8), 32'd0);
    check("rst_p4", 32'(p4), 32'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    // Directed cases
    run_op(8, 15, 13, 1'b0, "u_15x13");
    run_op(8, 8'hFF, 8'hFF, 1'b0, "u_max");
    run_op(8, 8'hFD, 5, 1'b1, "s_m3x5");
    run_op(8, 8'h80, 8'h80, 1'b1, "s_minxmin");
    run_op(8, 8'h80, 8'h7F, 1'b1, "s_minxmax");
    run_op(8, 0, 8'h5A, 1'b1, "s_zero_a");
    run_op(8, 8'h37, 0, 1'b0, "u_zero_b");
    run_op(4, 4'hF, 4'hF, 1'b0, "w4_u_max");
    run_op(4, 4'h8, 4'h8, 1'b1, "w4_s_minxmin");

    // Randomized cases on both widths
    for (int i = 0; i < 25; i++) begin
      run_op(8, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom), "rand8");
    end
    for (int i = 0; i < 12; i++) begin
      run_op(4, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom), "rand4");
    end

    // Start held high through RUN with changing operands
    ndone = 0;
    cap_a0 = $urandom_range(0, 255); cap_b0 = $urandom_range(0, 255);
    cap_a10 = $urandom_range(0, 255); cap_b10 = $urandom_range(0, 255);
    @(negedge Clk);
    for (int c = 0; c <= 30; c++) begin
      if (done8) begin
        if (ndone < 4) begin
          dcyc[ndone] = c;
          dp[ndone]   = 32'(p8);
        end
        ndone++;
      end
      if (c == 0)       set_in(8, 1'b1, cap_a0, cap_b0, 1'b0);
      else if (c == 10) set_in(8, 1'b1, cap_a10, cap_b10, 1'b1);
      else              set_in(8, c < 10, $urandom, $urandom, 1'($urandom));
      @(negedge Clk);
    end
    check("hold_done_count", 32'(ndone), 32'd2);
    if (ndone >= 2) begin
      check("hold_first_cycle", 32'(dcyc[0]), 32'd9);
      check("hold_first_p", dp[0], ref_prod(8, cap_a0, cap_b0, 1'b0));
      check("hold_second_cycle", 32'(dcyc[1]), 32'd19);
      check("hold_second_p", dp[1], ref_prod(8, cap_a10, cap_b10, 1'b1));
    end

    // Make P nonzero so the reset clear is observable
    run_op(8, 8'h12, 8'h34, 1'b0, "pre_rst");

    // Asynchronous reset in RUN cycle 4
    @(negedge Clk);
    set_in(8, 1'b1, 200, 100, 1'b0);
    @(negedge Clk);
    set_in(8, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge Clk);
    check("midrst_busy_before", 32'(busy8), 32'd1);
    #2 Rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_p", 32'(p8), 32'd0);
    @(negedge Clk);
    Rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done8 || busy8) ndone++;
      @(negedge Clk);
    end
    check("midrst_no_activity", 32'(ndone), 32'd0);
    run_op(8, 7, 9, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
